// File: rtl/eth_fcs_tx.sv
// Byte-wide Ethernet transmit framer: preamble/SFD insertion, zero padding to a
// minimum length, CRC-32 FCS append, underrun/oversize abort and inter-frame gap.
module eth_fcs_tx #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME      = 60,
    parameter int MAX_FRAME      = 1514,
    parameter int IFG_BYTES      = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  tx_d,
    output logic        tx_en,
    output logic        tx_er,
    output logic        frame_done,
    output logic [15:0] frames_sent,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a payload byte moves when s_valid & s_ready are both high at a
    // rising edge; s_ready is registered and only high while payload is being
    // taken (from the SFD cycle on) or while a dropped frame is being drained.
    // s_valid low while s_ready is high mid-frame is an underrun.

    localparam logic [15:0] PRE_N = 16'(PREAMBLE_BYTES);
    localparam logic [15:0] MIN_N = 16'(MIN_FRAME);
    localparam logic [15:0] MAX_N = 16'(MAX_FRAME);
    localparam logic [15:0] IFG_N = 16'(IFG_BYTES);

    // State names the kind of byte currently on tx_d.
    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DROP, IFG} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] len_q, len_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  tx_d_q, tx_d_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        s_ready_q, s_ready_d;
    logic        done_q, done_d;
    logic [15:0] sent_q, sent_d;
    logic [31:0] fcs_w;
    logic [1:0]  fcs_sel;
    logic        tail;

    // Reflected CRC-32 step, one byte, data LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs_w   = ~crc_q;
    assign fcs_sel = cnt_q[1:0] + 2'd1;
    // After the final payload byte (or a pad byte) the next byte is pad or FCS.
    assign tail    = ((state_q == DATA) && !s_ready_q) || (state_q == PAD);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        crc_d     = crc_q;
        tx_d_d    = 8'h00;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        s_ready_d = 1'b0;
        done_d    = 1'b0;
        sent_d    = sent_q;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    tx_en_d = 1'b1;
                    if (PRE_N == 16'd0) begin
                        tx_d_d    = 8'hD5;
                        s_ready_d = 1'b1;
                        crc_d     = 32'hFFFFFFFF;
                        len_d     = 16'd0;
                        state_d   = SFD;
                    end else begin
                        tx_d_d  = 8'h55;
                        cnt_d   = 16'd1;
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                tx_en_d = 1'b1;
                if (cnt_q >= PRE_N) begin
                    tx_d_d    = 8'hD5;
                    s_ready_d = 1'b1;
                    crc_d     = 32'hFFFFFFFF;
                    len_d     = 16'd0;
                    state_d   = SFD;
                end else begin
                    tx_d_d = 8'h55;
                    cnt_d  = cnt_q + 16'd1;
                end
            end
            SFD, DATA: begin
                if (s_ready_q) begin
                    tx_en_d = 1'b1;
                    if (!s_valid) begin
                        tx_er_d   = 1'b1;
                        s_ready_d = 1'b1;
                        state_d   = DROP;
                    end else if (len_q == MAX_N) begin
                        // Byte MAX_FRAME+1 is replaced by the error marker.
                        tx_er_d   = 1'b1;
                        s_ready_d = !s_last;
                        state_d   = DROP;
                    end else begin
                        tx_d_d    = s_data;
                        crc_d     = crc_byte(crc_q, s_data);
                        len_d     = len_q + 16'd1;
                        s_ready_d = !s_last;
                        state_d   = DATA;
                    end
                end
            end
            FCS: begin
                if (cnt_q == 16'd3) begin
                    cnt_d   = 16'd1;
                    state_d = IFG;
                end else begin
                    tx_en_d = 1'b1;
                    tx_d_d  = fcs_w[{fcs_sel, 3'b000} +: 8];
                    cnt_d   = cnt_q + 16'd1;
                    if (fcs_sel == 2'd3) begin
                        done_d = 1'b1;
                        sent_d = sent_q + 16'd1;
                    end
                end
            end
            DROP: begin
                // s_ready low here means s_last was already consumed.
                if (!s_ready_q || (s_valid && s_last)) begin
                    cnt_d   = 16'd1;
                    state_d = IFG;
                end else begin
                    s_ready_d = 1'b1;
                end
            end
            IFG: begin
                if (cnt_q >= IFG_N) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tail) begin
            tx_en_d = 1'b1;
            if (len_q < MIN_N) begin
                tx_d_d  = 8'h00;
                crc_d   = crc_byte(crc_q, 8'h00);
                len_d   = len_q + 16'd1;
                state_d = PAD;
            end else begin
                tx_d_d  = fcs_w[7:0];
                cnt_d   = 16'd0;
                state_d = FCS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= 16'd0;
            len_q     <= 16'd0;
            crc_q     <= 32'hFFFFFFFF;
            tx_d_q    <= 8'h00;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
            sent_q    <= 16'd0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            crc_q     <= crc_d;
            tx_d_q    <= tx_d_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            s_ready_q <= s_ready_d;
            done_q    <= done_d;
            sent_q    <= sent_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign tx_d        = tx_d_q;
    assign tx_en       = tx_en_q;
    assign tx_er       = tx_er_q;
    assign frame_done  = done_q;
    assign frames_sent = sent_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_eth_fcs_tx.sv
// Bench for eth_fcs_tx: line bytes are collected and compared with a frame model
// built from payload arrays and a bit-serial MSB-first CRC-32.
module tb_eth_fcs_tx;

    localparam int PRE_N = 7;
    localparam int MIN_N = 60;
    localparam int MAX_N = 1514;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  tx_d;
    logic        tx_en;
    logic        tx_er;
    logic        frame_done;
    logic [15:0] frames_sent;
    logic [2:0]  dbg_state;

    // Second instance with no minimum length, fed only for the check-value frame.
    logic        dut0_on;
    logic        s_valid0;
    logic        s_ready0;
    logic [7:0]  tx_d0;
    logic        tx_en0;
    logic        tx_er0;
    logic        frame_done0;
    logic [15:0] frames_sent0;
    logic [2:0]  dbg_state0;

    assign s_valid0 = s_valid && dut0_on;

    eth_fcs_tx u_dut (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_d(tx_d), .tx_en(tx_en), .tx_er(tx_er),
        .frame_done(frame_done), .frames_sent(frames_sent), .dbg_state_o(dbg_state)
    );

    eth_fcs_tx #(.MIN_FRAME(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid0), .s_last(s_last),
        .s_ready(s_ready0), .tx_d(tx_d0), .tx_en(tx_en0), .tx_er(tx_er0),
        .frame_done(frame_done0), .frames_sent(frames_sent0), .dbg_state_o(dbg_state0)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  obs_q[$];
    logic [7:0]  obs0_q[$];
    logic [7:0]  pl [0:2047];
    logic [15:0] exp_frames = 16'd0;
    int exp_done = 0;
    int done_cnt = 0;
    int done0_cnt = 0;
    int en_cycles = 0;
    int idle_bad = 0;
    int gap_cnt = 0;
    int last_gap = 0;
    logic prev_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- line monitor ----------------
    always @(posedge clk) begin
        #1;
        if (tx_en || tx_er) obs_q.push_back({tx_er, tx_en, tx_d});
        if (tx_en) en_cycles++;
        if (!tx_en && !tx_er && tx_d != 8'h00) idle_bad++;
        if (frame_done) done_cnt++;
        if (tx_en && !prev_en) last_gap = gap_cnt;
        gap_cnt = tx_en ? 0 : gap_cnt + 1;
        prev_en = tx_en;
        if (tx_en0 || tx_er0) obs0_q.push_back(tx_d0);
        if (frame_done0) done0_cnt++;
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] fcs_ref(input int n, input int total);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  b;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < total; i++) begin
            b = (i < n) ? pl[i] : 8'h00;
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ b[k];
                c  = c << 1;
                if (fb) c = c ^ 32'h04C11DB7;
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31-k];
        return ~r;
    endfunction

    // err_at < 0: good frame; otherwise err_at payload bytes precede the error marker.
    task automatic model_frame(input int n, input int err_at);
        int total;
        logic [31:0] f;
        for (int i = 0; i < PRE_N; i++) exp_q.push_back({2'b01, 8'h55});
        exp_q.push_back({2'b01, 8'hD5});
        if (err_at < 0) begin
            total = (n < MIN_N) ? MIN_N : n;
            for (int i = 0; i < total; i++) exp_q.push_back({2'b01, (i < n) ? pl[i] : 8'h00});
            f = fcs_ref(n, total);
            for (int k = 0; k < 4; k++) exp_q.push_back({2'b01, f[8*k +: 8]});
            exp_frames = exp_frames + 16'd1;
            exp_done++;
        end else begin
            for (int i = 0; i < err_at; i++) exp_q.push_back({2'b01, pl[i]});
            exp_q.push_back({2'b11, 8'h00});
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(0, 255));
    endtask

    // ---------------- driver ----------------
    task automatic drive_frame(input int n, input int stall_at, input bit keep_valid);
        int idx = 0;
        int low = 0;
        int budget = 0;
        bit rdy_prev;
        s_valid  = 1'b1;
        s_data   = pl[0];
        s_last   = (n == 1);
        rdy_prev = s_ready;
        while (idx < n && budget < 3 * n + 400) begin
            @(negedge clk);
            budget++;
            if (s_valid && rdy_prev) idx++;
            if (idx < n) begin
                if (idx == stall_at && low < 2) begin
                    s_valid = 1'b0;
                    low++;
                end else begin
                    s_valid = 1'b1;
                end
                s_data = pl[idx];
                s_last = (idx == n - 1);
            end
            rdy_prev = s_ready;
        end
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 8'h00;
        end
        check_eq("drive bytes accepted", idx, n);
    endtask

    task automatic check_stream(input string tag);
        int budget = 0;
        int mism = 0;
        int first = -1;
        while (obs_q.size() < exp_q.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        repeat (24) @(negedge clk);
        check_eq({tag, " line length"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) begin
                mism++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0)
            $display("  %s first difference at line byte %0d: got %03h want %03h (er,en,d)",
                     tag, first, obs_q[first], exp_q[first]);
        check_eq({tag, " byte differences"}, mism, 0);
        check_eq({tag, " frames_sent"}, frames_sent, exp_frames);
        check_eq({tag, " frame_done pulses"}, done_cnt, exp_done);
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] exp0_q[$];
        int mism0;
        int n;
        int stall;
        int budget;

        reset_n = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        dut0_on = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset tx_en", tx_en, 0);
        check_eq("reset tx_er", tx_er, 0);
        check_eq("reset tx_d", tx_d, 0);
        check_eq("reset s_ready", s_ready, 0);
        check_eq("reset frame_done", frame_done, 0);
        check_eq("reset frames_sent", frames_sent, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // ASCII check value, padded on the main instance, unpadded on the second.
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        dut0_on = 1'b1;
        model_frame(9, -1);
        drive_frame(9, -1, 1'b0);
        dut0_on = 1'b0;
        check_stream("ascii9");
        for (int i = 0; i < 7; i++) exp0_q.push_back(8'h55);
        exp0_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) exp0_q.push_back(8'h31 + 8'(i));
        exp0_q.push_back(8'h26);
        exp0_q.push_back(8'h39);
        exp0_q.push_back(8'hF4);
        exp0_q.push_back(8'hCB);
        check_eq("ascii9 nopad length", obs0_q.size(), exp0_q.size());
        mism0 = 0;
        for (int i = 0; i < exp0_q.size() && i < obs0_q.size(); i++)
            if (obs0_q[i] !== exp0_q[i]) mism0++;
        check_eq("ascii9 nopad byte differences", mism0, 0);
        check_eq("ascii9 nopad frame_done pulses", done0_cnt, 1);
        check_eq("ascii9 nopad frames_sent", frames_sent0, 1);

        // 14-byte frame: 46 pad bytes, 72 tx_en cycles.
        fill_random(14);
        en_cycles = 0;
        model_frame(14, -1);
        drive_frame(14, -1, 1'b0);
        check_stream("short14");
        check_eq("short14 tx_en cycles", en_cycles, 72);

        // Back-to-back frames with s_valid never dropping between them.
        fill_random(70);
        model_frame(70, -1);
        drive_frame(70, -1, 1'b1);
        fill_random(30);
        model_frame(30, -1);
        drive_frame(30, -1, 1'b0);
        check_stream("back2back");
        check_eq("back2back gap >= 12", (last_gap >= 12), 1);

        // Underrun at payload byte 20.
        fill_random(40);
        model_frame(40, 19);
        drive_frame(40, 19, 1'b0);
        check_stream("underrun20");

        // Oversize by one byte, then exactly the maximum.
        fill_random(MAX_N + 1);
        model_frame(MAX_N + 1, MAX_N);
        drive_frame(MAX_N + 1, -1, 1'b0);
        check_stream("oversize1515");
        fill_random(MAX_N);
        model_frame(MAX_N, -1);
        drive_frame(MAX_N, -1, 1'b0);
        check_stream("max1514");

        // Random frames, some with underrun.
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 120);
            stall = ($urandom_range(0, 3) == 0 && n >= 2) ? $urandom_range(1, n - 1) : -1;
            fill_random(n);
            model_frame(n, stall);
            drive_frame(n, stall, 1'b0);
            check_stream("random");
        end

        // Reset while the second FCS byte is on the line.
        fill_random(10);
        model_frame(10, -1);
        drive_frame(10, -1, 1'b0);
        budget = 0;
        while (obs_q.size() < 70 && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check_eq("midfcs reached FCS byte 2", obs_q.size(), 70);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("midfcs tx_en after reset", tx_en, 0);
        check_eq("midfcs tx_er after reset", tx_er, 0);
        check_eq("midfcs frames_sent after reset", frames_sent, 0);
        check_eq("midfcs s_ready after reset", s_ready, 0);
        reset_n = 1'b1;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        exp_frames = 16'd0;
        exp_done--;
        check_stream("midfcs");
        n = $urandom_range(1, 90);
        fill_random(n);
        model_frame(n, -1);
        drive_frame(n, -1, 1'b0);
        check_stream("after reset");

        check_eq("tx_d zero while idle", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
